acc_arbiter: RTL
================

Name: acc_arbiter

Overview:
- Shares one acc_core accumulator between NUM_REQ requesters.
- Grants requesters round-robin and owns the core's run/valid/number inputs.
- For each granted job, forwards len numbers from the winner into the core, one at a time. It returns the final accumulated result to that requester with a done pulse.
- Sits between the requester-side stream sources and a single acc_core instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- IN_DATA_WIDTH, 8, width of each number.
- DWIDTH, IN_DATA_WIDTH*4, accumulator/result width.
- LEN_WIDTH, 8, width of per-job number count.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester job request (level).
- len_i  input  NUM_REQ*LEN_WIDTH  per-requester count of numbers in its job; slice k at [k*LEN_WIDTH +: LEN_WIDTH].
- num_valid_i  input  NUM_REQ  per-requester number valid.
- num_i  input  NUM_REQ*IN_DATA_WIDTH  per-requester number; slice k at [k*IN_DATA_WIDTH +: IN_DATA_WIDTH].
- num_ready_o  output  NUM_REQ  per-requester number ready.
- gnt_o  output  NUM_REQ  one-hot grant; held for the whole job.
- done_o  output  NUM_REQ  one-cycle job-complete pulse to the granted requester.
- result_o  output  DWIDTH  final result of the last completed job.
- core_run_o  output  1  drives acc_core run_i.
- core_valid_o  output  1  drives acc_core valid_i.
- core_number_o  output  IN_DATA_WIDTH  drives acc_core number_i.
- core_valid_i  input  1  from acc_core valid_o.
- core_result_i  input  DWIDTH  from acc_core result_o.

Behaviour:
- Core contract:
  - core_run_o low for at least one cycle clears the accumulator.
  - Each one-cycle core_valid_o while core_run_o is high adds core_number_o.
  - The core answers each add with one core_valid_i pulse carrying the updated sum, after any latency of 1 or more cycles.
- Reset values (asserted asynchronously): state IDLE; gnt_o, done_o, num_ready_o, core_run_o, core_valid_o all 0; core_number_o 0; result_o 0; counters 0; RR pointer 0.
- FSM states: IDLE, FEED, WAIT, DONE.
- IDLE:
  - core_run_o=0, gnt_o=0.
  - If any req_i bit is set, grant the first set bit found searching upward (wrapping) from the RR pointer.
  - Latch len_i of the winner into len_r and clear the sent/ack counters.
  - If len_r==0, go to DONE with result register 0; otherwise go to FEED.
  - gnt_o is registered: it rises the cycle the state leaves IDLE.
  - core_valid_i seen in IDLE is ignored.
- FEED:
  - core_run_o=1.
  - num_ready_o[g]=1 only while no add is outstanding and sent<len_r; all other num_ready_o bits are 0.
  - On a transfer (num_valid_i[g] & num_ready_o[g]) at edge t: core_valid_o=1 and core_number_o=num for exactly cycle t+1; sent increments; go to WAIT.
- WAIT:
  - core_run_o=1, num_ready_o=0.
  - On core_valid_i: increment ack.
  - If ack+1==len_r, capture core_result_i into result_o and go to DONE; otherwise return to FEED.
- DONE:
  - core_run_o=0 (this guarantees the clear cycle between jobs).
  - done_o[g]=1 for this single cycle.
  - result_o is valid and held until the next DONE.
  - Set RR pointer to g+1 mod NUM_REQ; drop gnt_o; go to IDLE.
- Only one add is ever outstanding, so core_valid_o never pulses twice without an intervening core_valid_i.
- req_i deasserted mid-job is ignored; the job runs to len_r.
- Changes to len_i during a job are ignored.
- Extra core_valid_i pulses in FEED are ignored.
- Minimum job time for len L with core latency 1: L*3 + 2 cycles.

Test Plan:
- Req0 len=2, numbers 1 then 3, core model latency 1 -> core_valid_o pulses with 1, 3; done_o=01 with result_o=4; core_run_o low again in DONE.
- Req0 and req1 both assert after reset, len=1 each, numbers 5 and 7 -> req0 served first (result 5, done_o=01), then req1 (result 7, done_o=10). There is a core_run_o low cycle between the jobs.
- Req1 len=0 -> done_o=10 two cycles after req, result_o=0, core_run_o and core_valid_o never assert.
- Req0 len=3, numbers 2, 4, 6 with num_valid_i gaps of 2 cycles and core latency 3 -> no second core_valid_o before core_valid_i; result_o=12.
- Req0 held continuously with req1 also held, len=1 -> grants alternate 0, 1, 0, 1 over four jobs.
- reset pulsed mid-WAIT of a len=3 job -> all outputs return to reset values immediately; a following req1 len=1 job with number 9 yields result_o=9.

Source files
------------

// File: rtl/acc_arbiter.sv
// Round-robin arbiter that time-shares one acc_core accumulator between NUM_REQ
// requesters, streaming each winner's job into the core and returning its sum.
module acc_arbiter #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned DWIDTH        = IN_DATA_WIDTH * 4,
    parameter int unsigned LEN_WIDTH     = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_i,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]     len_i,
    input  logic [NUM_REQ-1:0]               num_valid_i,
    input  logic [NUM_REQ*IN_DATA_WIDTH-1:0] num_i,
    output logic [NUM_REQ-1:0]               num_ready_o,
    output logic [NUM_REQ-1:0]               gnt_o,
    output logic [NUM_REQ-1:0]               done_o,
    output logic [DWIDTH-1:0]                result_o,
    output logic                             core_run_o,
    output logic                             core_valid_o,
    output logic [IN_DATA_WIDTH-1:0]         core_number_o,
    input  logic                             core_valid_i,
    input  logic [DWIDTH-1:0]                core_result_i
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [PTR_W-1:0]         r_rr;
    logic [PTR_W-1:0]         r_gidx;
    logic [LEN_WIDTH-1:0]     r_len;
    logic [LEN_WIDTH-1:0]     r_sent;
    logic [LEN_WIDTH-1:0]     r_ack;
    logic [NUM_REQ-1:0]       r_gnt;
    logic [NUM_REQ-1:0]       r_done;
    logic [NUM_REQ-1:0]       r_ready;
    logic [DWIDTH-1:0]        r_result;
    logic                     r_core_run;
    logic                     r_core_valid;
    logic [IN_DATA_WIDTH-1:0] r_core_number;

    logic [LEN_WIDTH-1:0]     w_lens [NUM_REQ];
    logic [IN_DATA_WIDTH-1:0] w_nums [NUM_REQ];
    logic                     w_any;
    logic [PTR_W-1:0]         w_win;
    logic [PTR_W-1:0]         w_cand;
    logic [NUM_REQ-1:0]       w_win_onehot;
    logic [LEN_WIDTH-1:0]     w_win_len;
    logic                     w_xfer;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_split
        assign w_lens[k] = len_i[k*LEN_WIDTH +: LEN_WIDTH];
        assign w_nums[k] = num_i[k*IN_DATA_WIDTH +: IN_DATA_WIDTH];
    end

    // First requesting index at or above the RR pointer, wrapping.
    always_comb begin
        w_any  = 1'b0;
        w_win  = '0;
        w_cand = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            w_cand = PTR_W'((32'(r_rr) + i) % NUM_REQ);
            if (!w_any && req_i[w_cand]) begin
                w_any = 1'b1;
                w_win = w_cand;
            end
        end
    end

    assign w_win_onehot = NUM_REQ'(1) << w_win;
    assign w_win_len    = w_lens[w_win];
    assign w_xfer       = num_valid_i[r_gidx] & r_ready[r_gidx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_rr          <= '0;
            r_gidx        <= '0;
            r_len         <= '0;
            r_sent        <= '0;
            r_ack         <= '0;
            r_gnt         <= '0;
            r_done        <= '0;
            r_ready       <= '0;
            r_result      <= '0;
            r_core_run    <= 1'b0;
            r_core_valid  <= 1'b0;
            r_core_number <= '0;
        end else begin
            r_core_valid <= 1'b0;
            r_done       <= '0;
            case (r_state)
                S_IDLE: begin
                    r_core_run <= 1'b0;
                    r_gnt      <= '0;
                    r_ready    <= '0;
                    if (w_any) begin
                        r_gidx <= w_win;
                        r_gnt  <= w_win_onehot;
                        r_len  <= w_win_len;
                        r_sent <= '0;
                        r_ack  <= '0;
                        if (w_win_len == '0) begin
                            r_result <= '0;
                            r_done   <= w_win_onehot;
                            r_state  <= S_DONE;
                        end else begin
                            r_core_run <= 1'b1;
                            r_ready    <= w_win_onehot;
                            r_state    <= S_FEED;
                        end
                    end
                end
                S_FEED: begin
                    // One number in flight at a time; stray core_valid_i here is dropped.
                    if (w_xfer) begin
                        r_core_valid  <= 1'b1;
                        r_core_number <= w_nums[r_gidx];
                        r_sent        <= r_sent + LEN_WIDTH'(1);
                        r_ready       <= '0;
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (core_valid_i) begin
                        r_ack <= r_ack + LEN_WIDTH'(1);
                        if (r_ack + LEN_WIDTH'(1) == r_len) begin
                            r_result   <= core_result_i;
                            r_done     <= r_gnt;
                            r_core_run <= 1'b0;
                            r_state    <= S_DONE;
                        end else begin
                            r_ready <= (r_sent < r_len) ? r_gnt : '0;
                            r_state <= S_FEED;
                        end
                    end
                end
                S_DONE: begin
                    r_gnt   <= '0;
                    r_rr    <= (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign num_ready_o   = r_ready;
    assign gnt_o         = r_gnt;
    assign done_o        = r_done;
    assign result_o      = r_result;
    assign core_run_o    = r_core_run;
    assign core_valid_o  = r_core_valid;
    assign core_number_o = r_core_number;

endmodule
